// File: rtl/cube_sum_verifier_if.sv
// Candidate/result handshake bundle for cube_sum_verifier.
interface cube_sum_verifier_if #(
  parameter int W  = 16,
  parameter int RW = 3*W+2
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic          a_neg;
  logic [W-1:0]  b;
  logic          b_neg;
  logic [RW-1:0] target;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] sum;
  logic          match;

  modport master (
    output in_valid, a, a_neg, b, b_neg, target, out_ready,
    input  in_ready, out_valid, sum, match
  );

  modport slave (
    input  in_valid, a, a_neg, b, b_neg, target, out_ready,
    output in_ready, out_valid, sum, match
  );
endinterface

// File: rtl/cube_sum_verifier.sv
// Computes (+-a)^3 + (+-b)^3 with one shared shift-add multiplier and compares to target.
// Optional: CUBE_ZERO_SKIP_EN skips the square/cube passes of a zero-magnitude operand.
module cube_sum_verifier #(
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  cube_sum_verifier_if.slave   bus,
  output logic                 busy
);
  localparam int RW = 3*W+2;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W-1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQ_A = 3'd1,
    CU_A = 3'd2,
    SQ_B = 3'd3,
    CU_B = 3'd4,
    SUM  = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic            a_neg_r;
  logic            b_neg_r;
  logic [RW-1:0]   target_r;
  logic [W-1:0]    mplier_r;
  logic [3*W-1:0]  mcand_r;
  logic [3*W-1:0]  acc_r;
  logic [3*W-1:0]  ca_r;
  logic [3*W-1:0]  cb_r;
  logic [RW-1:0]   sum_r;
  logic            match_r;
  logic            out_valid_r;
  logic            in_ready_r;
  logic            busy_r;

  logic [3*W-1:0]  acc_add_s;
  logic [RW-1:0]   sa_s;
  logic [RW-1:0]   sb_s;
  logic [RW-1:0]   sum_s;

  // Shift-add step and signed final sum
  always_comb begin
    acc_add_s = acc_r + (mplier_r[0] ? mcand_r : '0);
    if (a_neg_r) begin
      sa_s = '0 - {2'b00, ca_r};
    end else begin
      sa_s = {2'b00, ca_r};
    end
    if (b_neg_r) begin
      sb_s = '0 - {2'b00, cb_r};
    end else begin
      sb_s = {2'b00, cb_r};
    end
    sum_s = sa_s + sb_s;
  end

  // Control FSM and multiplier datapath
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      a_r         <= '0;
      b_r         <= '0;
      a_neg_r     <= 1'b0;
      b_neg_r     <= 1'b0;
      target_r    <= '0;
      mplier_r    <= '0;
      mcand_r     <= '0;
      acc_r       <= '0;
      ca_r        <= '0;
      cb_r        <= '0;
      sum_r       <= '0;
      match_r     <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            a_r        <= bus.a;
            b_r        <= bus.b;
            a_neg_r    <= bus.a_neg;
            b_neg_r    <= bus.b_neg;
            target_r   <= bus.target;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            cnt_r      <= '0;
            acc_r      <= '0;
`ifdef CUBE_ZERO_SKIP_EN
            if (bus.a != '0) begin
              mcand_r  <= {{(2*W){1'b0}}, bus.a};
              mplier_r <= bus.a;
              state_r  <= SQ_A;
            end else if (bus.b != '0) begin
              ca_r     <= '0;
              mcand_r  <= {{(2*W){1'b0}}, bus.b};
              mplier_r <= bus.b;
              state_r  <= SQ_B;
            end else begin
              ca_r     <= '0;
              cb_r     <= '0;
              state_r  <= SUM;
            end
`else
            mcand_r  <= {{(2*W){1'b0}}, bus.a};
            mplier_r <= bus.a;
            state_r  <= SQ_A;
`endif
          end
        end
        SQ_A, CU_A, SQ_B, CU_B: begin
          if (cnt_r != CNT_LAST) begin
            acc_r    <= acc_add_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CW'(1);
          end else begin
            cnt_r <= '0;
            acc_r <= '0;
            case (state_r)
              SQ_A: begin
                mcand_r  <= {{W{1'b0}}, acc_add_s[2*W-1:0]};
                mplier_r <= a_r;
                state_r  <= CU_A;
              end
              CU_A: begin
                ca_r <= acc_add_s;
`ifdef CUBE_ZERO_SKIP_EN
                if (b_r != '0) begin
                  mcand_r  <= {{(2*W){1'b0}}, b_r};
                  mplier_r <= b_r;
                  state_r  <= SQ_B;
                end else begin
                  cb_r    <= '0;
                  state_r <= SUM;
                end
`else
                mcand_r  <= {{(2*W){1'b0}}, b_r};
                mplier_r <= b_r;
                state_r  <= SQ_B;
`endif
              end
              SQ_B: begin
                mcand_r  <= {{W{1'b0}}, acc_add_s[2*W-1:0]};
                mplier_r <= b_r;
                state_r  <= CU_B;
              end
              CU_B: begin
                cb_r    <= acc_add_s;
                state_r <= SUM;
              end
              default: state_r <= IDLE;
            endcase
          end
        end
        SUM: begin
          sum_r       <= sum_s;
          match_r     <= (sum_s == target_r);
          out_valid_r <= 1'b1;
          state_r     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.match     = match_r;
  assign busy          = busy_r;
endmodule

// File: tb/tb_cube_sum_verifier.sv
// Randomized self-checking bench for cube_sum_verifier against an arithmetic reference model.
module tb_cube_sum_verifier;
  localparam int W  = 16;
  localparam int RW = 3*W+2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  cube_sum_verifier_if #(.W(W)) bus();

  cube_sum_verifier #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] ref_sum(input int unsigned a, input bit an,
                                            input int unsigned b, input bit bn);
    longint ca, cb, s;
    ca = longint'(a) * longint'(a) * longint'(a);
    cb = longint'(b) * longint'(b) * longint'(b);
    if (an) ca = -ca;
    if (bn) cb = -cb;
    s = ca + cb;
    return s[RW-1:0];
  endfunction

  function automatic int ref_latency(input int unsigned a, input int unsigned b);
`ifdef CUBE_ZERO_SKIP_EN
    return ((a != 0) ? 2*W : 0) + ((b != 0) ? 2*W : 0) + 1;
`else
    return 4*W + 1;
`endif
  endfunction

  task automatic run_txn(input int unsigned a, input bit an, input int unsigned b, input bit bn,
                         input logic [RW-1:0] tgt, input int hold);
    logic [RW-1:0] es;
    logic [63:0]   rnd;
    int            edges;
    es = ref_sum(a, an, b, bn);
    @(negedge clk);
    check_val("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.a         = W'(a);
    bus.a_neg     = an;
    bus.b         = W'(b);
    bus.b_neg     = bn;
    bus.target    = tgt;
    bus.out_ready = (hold == 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rnd = {$urandom, $urandom};
    bus.a      = W'($urandom);
    bus.b      = W'($urandom);
    bus.a_neg  = rnd[0];
    bus.target = rnd[RW-1:0];
    check_val("in_ready_after_accept", 64'(bus.in_ready), 64'd0);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!bus.out_valid && edges < 300);
    check_val("latency", 64'(edges), 64'(ref_latency(a, b)));
    check_val("sum", 64'(bus.sum), 64'(es));
    check_val("match", 64'(bus.match), 64'(es == tgt));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        @(posedge clk);
        #1;
        check_val("hold_valid", 64'(bus.out_valid), 64'd1);
        check_val("hold_sum", 64'(bus.sum), 64'(es));
        check_val("hold_in_ready", 64'(bus.in_ready), 64'd0);
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check_val("post_hs_valid", 64'(bus.out_valid), 64'd0);
    check_val("post_hs_in_ready", 64'(bus.in_ready), 64'd1);
    check_val("post_hs_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    longint        tmax;
    logic [RW-1:0] tgt;
    logic [63:0]   rt;
    int unsigned   ra, rb;
    int            seen;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.a_neg     = 1'b0;
    bus.b         = '0;
    bus.b_neg     = 1'b0;
    bus.target    = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_sum", 64'(bus.sum), 64'd0);
    check_val("rst_match", 64'(bus.match), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_txn(3, 1'b0, 4, 1'b0, RW'(91), 0);
    run_txn(12, 1'b0, 1, 1'b0, RW'(1729), 0);
    run_txn(10, 1'b0, 9, 1'b0, RW'(1729), 0);
    run_txn(5, 1'b1, 3, 1'b0, RW'(0), 0);
    tmax = -(64'sd2 * 64'sd65535 * 64'sd65535 * 64'sd65535);
    tgt  = tmax[RW-1:0];
    run_txn(65535, 1'b1, 65535, 1'b1, tgt, 0);
    run_txn(7, 1'b0, 2, 1'b1, RW'(335), 10);
    run_txn(0, 1'b0, 7, 1'b0, RW'(343), 0);
    run_txn(0, 1'b1, 0, 1'b1, RW'(0), 0);
    run_txn(6, 1'b0, 0, 1'b1, RW'(216), 2);

    // Abort an operation with reset and make sure no partial result escapes
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = W'(200);
    bus.b        = W'(300);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_val("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check_val("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("abort_sum", 64'(bus.sum), 64'd0);
    check_val("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check_val("abort_no_result", 64'(seen), 64'd0);

    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 7))
        0:       ra = 0;
        1:       ra = 65535;
        default: ra = $urandom_range(0, 65535);
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 0;
        1:       rb = 65535;
        default: rb = $urandom_range(0, 65535);
      endcase
      if ($urandom_range(0, 1) == 1) begin
        rt  = {$urandom, $urandom};
        tgt = rt[RW-1:0];
      end else begin
        tgt = RW'(0);
      end
      if ($urandom_range(0, 1) == 1) begin
        run_txn(ra, 1'($urandom), rb, 1'($urandom), tgt, $urandom_range(0, 2));
      end else begin
        run_txn(ra, 1'b0, rb, 1'b1, ref_sum(ra, 1'b0, rb, 1'b1), $urandom_range(0, 2));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
